sigma_mem_arbiter: RTL and testbench
====================================

Name: sigma_mem_arbiter

Overview:
Single-port core-memory arbiter for the Sigma-style CPU. It shares one word-addressed memory port (address bits 15:31, 32-bit data) between three requesters: the CPU fetch/operand path and two IOP channels. It sequences each access with a timeout watchdog and returns read data with a one-cycle acknowledge.

Parameters:
TIMEOUT, 16, cycles in BUSY without mem_done before the access is aborted (range 2..255).
STARVE_LIMIT, 4, consecutive IOP grants made while the CPU is requesting, after which the CPU wins the next arbitration (range 1..15).

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-low reset
cpu_req, iop0_req, iop1_req  in  1 each  access request; held until the matching ack
cpu_we, iop0_we, iop1_we  in  1 each  1 = write, 0 = read
cpu_addr, iop0_addr, iop1_addr  in  [15:31] each  word address
cpu_wdata, iop0_wdata, iop1_wdata  in  [0:31] each  write data
cpu_ack, iop0_ack, iop1_ack  out  1 each  one-cycle completion pulse
rd_data  out  [0:31]  read data; valid while any ack is high
err  out  1  high with ack when the access timed out
mem_req  out  1  memory access strobe; held high for the whole access
mem_we  out  1  latched write enable
mem_addr  out  [15:31]  latched address
mem_wdata  out  [0:31]  latched write data
mem_rdata  in  [0:31]  memory read data; valid with mem_done
mem_done  in  1  one-cycle completion from memory
busy  out  1  high in BUSY and DONE
grant  out  [0:1]  0 = cpu, 1 = iop0, 2 = iop1, 3 = none
timeout_flag  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset (reset==0 at a rising edge):
  - state goes to IDLE.
  - All acks, err, mem_req, mem_we, busy and timeout_flag go to 0.
  - mem_addr, mem_wdata and rd_data go to 0; grant goes to 3.
  - Round-robin pointer goes to iop0; starve counter and timeout counter go to 0.
  - Reset in the middle of an access abandons it silently: no ack is issued.
- States: IDLE, BUSY, DONE.
- IDLE, with any request pending:
  - Select a winner. Latch its we, addr and wdata into mem_*.
  - Set mem_req=1, set grant, load the timeout counter with 0, go to BUSY.
  - With no request pending, stay in IDLE with grant=3.
- Arbitration:
  - If cpu_req and starve counter == STARVE_LIMIT: the CPU wins.
  - Otherwise, if any IOP is requesting, an IOP wins. If both request, the one named by the round-robin pointer wins.
  - Otherwise the CPU wins.
  - After an IOP grant, the pointer moves to the other IOP.
  - On an IOP grant while cpu_req is high, the starve counter increments (saturating at STARVE_LIMIT).
  - On a CPU grant, or in any IDLE cycle with cpu_req low, the starve counter clears.
- BUSY:
  - mem_* are held stable. The timeout counter increments every cycle.
  - If mem_done: capture rd_data=mem_rdata for a read (for a write, rd_data is left unchanged), set err=0, drop mem_req, go to DONE.
  - Else, if the counter reaches TIMEOUT-1: set rd_data=0 and err=1, set timeout_flag, drop mem_req, go to DONE.
  - If mem_done arrives in the same cycle the counter reaches TIMEOUT-1, mem_done wins: no error.
- DONE (exactly one cycle):
  - The ack of the granted requester is 1; all other acks are 0. err is valid.
  - Requests are ignored this cycle; the requester drops req at this edge.
  - Next state IDLE; ack and err return to 0, grant returns to 3.
- A mem_done seen in IDLE or DONE is ignored.
- Latency: req seen in IDLE cycle 0 -> mem_req high from cycle 1. mem_done in cycle n -> ack in cycle n+1 -> IDLE in cycle n+2. The minimum round trip is 3 cycles from request to the next arbitration.
- A requester that keeps req high after its ack is treated as making a new request.

Test Plan:
- CPU read of addr 17'h00100, memory returns 32'h22100005 with mem_done 2 cycles after mem_req -> mem_addr=17'h00100 and mem_we=0; cpu_ack pulses one cycle with rd_data=32'h22100005 and err=0; busy drops the following cycle.
- iop0 write of 32'hDEADBEEF to 17'h01FFF while cpu_req is also high -> iop0 is granted first, mem_we=1, mem_wdata=32'hDEADBEEF; the CPU is granted on the next arbitration.
- iop0, iop1 and cpu held continuously requesting, STARVE_LIMIT=4 -> grant sequence iop0, iop1, iop0, iop1, cpu, then repeating.
- mem_done never asserted, TIMEOUT=16 -> exactly 16 cycles of mem_req, then the ack with err=1 and rd_data=0; timeout_flag stays 1 until reset.
- mem_done coincides with the final timeout cycle -> normal ack, err=0, timeout_flag stays 0.
- reset driven low during BUSY -> next cycle mem_req=0, no ack, grant=3; a fresh cpu request after reset completes normally.

Source files
------------

// File: rtl/sigma_mem_arbiter_if.sv
// Bus bundle between the Sigma memory arbiter, its three requesters and the core-memory port.
// The arbiter uses the slave view; the requester/memory environment uses the master view.
interface sigma_mem_arbiter_if;
    logic        cpu_req,   iop0_req,   iop1_req;
    logic        cpu_we,    iop0_we,    iop1_we;
    logic [15:31] cpu_addr, iop0_addr,  iop1_addr;
    logic [0:31] cpu_wdata, iop0_wdata, iop1_wdata;
    logic        cpu_ack,   iop0_ack,   iop1_ack;
    logic [0:31] rd_data;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [15:31] mem_addr;
    logic [0:31] mem_wdata;
    logic [0:31] mem_rdata;
    logic        mem_done;
    logic        busy;
    logic [0:1]  grant;
    logic        timeout_flag;

    modport slave (
        input  cpu_req, iop0_req, iop1_req,
        input  cpu_we, iop0_we, iop1_we,
        input  cpu_addr, iop0_addr, iop1_addr,
        input  cpu_wdata, iop0_wdata, iop1_wdata,
        input  mem_rdata, mem_done,
        output cpu_ack, iop0_ack, iop1_ack,
        output rd_data, err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output busy, grant, timeout_flag
    );

    modport master (
        output cpu_req, iop0_req, iop1_req,
        output cpu_we, iop0_we, iop1_we,
        output cpu_addr, iop0_addr, iop1_addr,
        output cpu_wdata, iop0_wdata, iop1_wdata,
        output mem_rdata, mem_done,
        input  cpu_ack, iop0_ack, iop1_ack,
        input  rd_data, err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  busy, grant, timeout_flag
    );
endinterface

// File: rtl/sigma_mem_arbiter.sv
// Single-port core-memory arbiter: CPU vs two IOP channels, round-robin between IOPs with a
// CPU anti-starvation limit, per-access timeout watchdog and a one-cycle acknowledge.
module sigma_mem_arbiter #(
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    sigma_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [16:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [1:0] G_CPU  = 2'd0;
    localparam logic [1:0] G_IOP0 = 2'd1;
    localparam logic [1:0] G_IOP1 = 2'd2;
    localparam logic [1:0] G_NONE = 2'd3;
    localparam logic [3:0] SLIM   = 4'(STARVE_LIMIT);
    localparam logic [7:0] TLAST  = 8'(TIMEOUT - 1);

    state_t      r_state, w_state;
    logic [1:0]  r_grant, w_grant;
    logic        r_rr, w_rr;
    logic [3:0]  r_starve, w_starve;
    logic [7:0]  r_tcnt, w_tcnt;
    logic        r_mem_req, w_mem_req;
    logic        r_mem_we, w_mem_we;
    logic [16:0] r_mem_addr, w_mem_addr;
    logic [31:0] r_mem_wdata, w_mem_wdata;
    logic [31:0] r_rd_data, w_rd_data;
    logic        r_err, w_err;
    logic        r_tflag, w_tflag;

    logic [2:0]       w_req;
    req_t [2:0]       w_reqs;
    logic [1:0]       w_win;

    assign w_req     = {bus.iop1_req, bus.iop0_req, bus.cpu_req};
    assign w_reqs[0] = {bus.cpu_we,  bus.cpu_addr,  bus.cpu_wdata};
    assign w_reqs[1] = {bus.iop0_we, bus.iop0_addr, bus.iop0_wdata};
    assign w_reqs[2] = {bus.iop1_we, bus.iop1_addr, bus.iop1_wdata};

    // r_rr names the IOP that wins a tie (0 = iop0, 1 = iop1).
    always_comb begin
        w_win = G_NONE;
        if (w_req[0] && r_starve == SLIM)
            w_win = G_CPU;
        else if (w_req[1] && w_req[2])
            w_win = r_rr ? G_IOP1 : G_IOP0;
        else if (w_req[1])
            w_win = G_IOP0;
        else if (w_req[2])
            w_win = G_IOP1;
        else if (w_req[0])
            w_win = G_CPU;
    end

    always_comb begin
        w_state     = r_state;
        w_grant     = r_grant;
        w_rr        = r_rr;
        w_starve    = r_starve;
        w_tcnt      = r_tcnt;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_rd_data   = r_rd_data;
        w_err       = r_err;
        w_tflag     = r_tflag;
        case (r_state)
            IDLE: begin
                if (!w_req[0])
                    w_starve = '0;
                if (w_win != G_NONE) begin
                    w_mem_we    = w_reqs[w_win].we;
                    w_mem_addr  = w_reqs[w_win].addr;
                    w_mem_wdata = w_reqs[w_win].wdata;
                    w_mem_req   = 1'b1;
                    w_grant     = w_win;
                    w_tcnt      = '0;
                    w_state     = BUSY;
                    if (w_win == G_CPU) begin
                        w_starve = '0;
                    end else begin
                        w_rr = (w_win == G_IOP0);
                        if (w_req[0] && r_starve != SLIM)
                            w_starve = r_starve + 4'd1;
                    end
                end else begin
                    w_grant = G_NONE;
                end
            end
            BUSY: begin
                w_tcnt = r_tcnt + 8'd1;
                // A completion on the last watchdog cycle still counts as a good access.
                if (bus.mem_done) begin
                    if (!r_mem_we)
                        w_rd_data = bus.mem_rdata;
                    w_err     = 1'b0;
                    w_mem_req = 1'b0;
                    w_state   = DONE;
                end else if (r_tcnt == TLAST) begin
                    w_rd_data = '0;
                    w_err     = 1'b1;
                    w_tflag   = 1'b1;
                    w_mem_req = 1'b0;
                    w_state   = DONE;
                end
            end
            DONE: begin
                w_err   = 1'b0;
                w_grant = G_NONE;
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_grant     <= G_NONE;
            r_rr        <= 1'b0;
            r_starve    <= '0;
            r_tcnt      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_data   <= '0;
            r_err       <= 1'b0;
            r_tflag     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_grant     <= w_grant;
            r_rr        <= w_rr;
            r_starve    <= w_starve;
            r_tcnt      <= w_tcnt;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_rd_data   <= w_rd_data;
            r_err       <= w_err;
            r_tflag     <= w_tflag;
        end
    end

    assign bus.cpu_ack      = (r_state == DONE) && (r_grant == G_CPU);
    assign bus.iop0_ack     = (r_state == DONE) && (r_grant == G_IOP0);
    assign bus.iop1_ack     = (r_state == DONE) && (r_grant == G_IOP1);
    assign bus.rd_data      = r_rd_data;
    assign bus.err          = r_err;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.busy         = (r_state != IDLE);
    assign bus.grant        = r_grant;
    assign bus.timeout_flag = r_tflag;

    a_ack_onehot: assert property (@(posedge i_clock) disable iff (!i_reset)
        $onehot0({bus.cpu_ack, bus.iop0_ack, bus.iop1_ack}));
    a_req_in_busy: assert property (@(posedge i_clock) disable iff (!i_reset)
        bus.mem_req |-> (r_state == BUSY));
endmodule

// File: tb/tb_sigma_mem_arbiter.sv
// Self-checking bench for sigma_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration, starvation and timeout rules.
module tb_sigma_mem_arbiter;
    localparam int TIMEOUT = 16;
    localparam int SLIM    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sigma_mem_arbiter_if bus();

    sigma_mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(SLIM)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    logic        rq[3];
    logic        rwe[3];
    logic [16:0] raddr[3];
    logic [31:0] rwd[3];

    assign bus.cpu_req    = rq[0];
    assign bus.iop0_req   = rq[1];
    assign bus.iop1_req   = rq[2];
    assign bus.cpu_we     = rwe[0];
    assign bus.iop0_we    = rwe[1];
    assign bus.iop1_we    = rwe[2];
    assign bus.cpu_addr   = raddr[0];
    assign bus.iop0_addr  = raddr[1];
    assign bus.iop1_addr  = raddr[2];
    assign bus.cpu_wdata  = rwd[0];
    assign bus.iop0_wdata = rwd[1];
    assign bus.iop1_wdata = rwd[2];

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        none;
        logic        hung;
        logic [1:0]  grant;
        logic        we;
        logic [16:0] addr;
        logic [31:0] wdata;
        int          req_cycles;
        logic [2:0]  ack;
        logic [31:0] rd;
        logic        err;
        logic        tflag;
        logic        busy_after;
        logic [1:0]  grant_after;
        logic [2:0]  ack_after;
    } obs_t;

    task automatic clear_reqs();
        for (int i = 0; i < 3; i++) rq[i] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_reqs();
        bus.mem_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one arbitration from an IDLE negedge; mem_done is pulsed in BUSY cycle 'dly'
    // (counting from 0). Observations only; the calling test does the comparisons.
    task automatic access(input int dly, input logic [31:0] rdat, input logic drop, output obs_t o);
        int cnt;
        o.none = 1'b0; o.hung = 1'b0; o.req_cycles = 0; o.ack = '0;
        @(negedge clk);
        o.grant = bus.grant; o.we = bus.mem_we; o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
        o.rd = bus.rd_data; o.err = bus.err; o.tflag = bus.timeout_flag;
        o.busy_after = bus.busy; o.grant_after = bus.grant; o.ack_after = '0;
        if (!bus.mem_req) begin
            o.none = 1'b1;
            return;
        end
        cnt = 0;
        forever begin
            bus.mem_done = 1'b0;
            o.ack = {bus.iop1_ack, bus.iop0_ack, bus.cpu_ack};
            if (o.ack != 3'b000) break;
            if (bus.mem_req) o.req_cycles++;
            if (cnt == dly) begin
                bus.mem_done  = 1'b1;
                bus.mem_rdata = rdat;
            end else begin
                bus.mem_rdata = $urandom;
            end
            cnt++;
            if (cnt > 400) begin
                o.hung = 1'b1;
                break;
            end
            @(negedge clk);
        end
        o.rd = bus.rd_data; o.err = bus.err; o.tflag = bus.timeout_flag;
        if (drop)
            for (int i = 0; i < 3; i++) if (o.ack[i]) rq[i] = 1'b0;
        @(negedge clk);
        o.busy_after  = bus.busy;
        o.grant_after = bus.grant;
        o.ack_after   = {bus.iop1_ack, bus.iop0_ack, bus.cpu_ack};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rq[i] = 1'b1; rwe[i] = 1'b1; raddr[i] = 17'h1ABCD; rwd[i] = 32'hFFFF0000;
        end
        rst_n = 1'b0;
        bus.mem_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got=%b want=0", bus.mem_req); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.grant !== 2'd3) begin fails++; $display("FAIL reset_grant got=%0d want=3", bus.grant); end
        checks++; if ({bus.cpu_ack, bus.iop0_ack, bus.iop1_ack, bus.err, bus.mem_we, bus.timeout_flag} !== 6'b0)
            begin fails++; $display("FAIL reset_flags got=%b want=000000", {bus.cpu_ack, bus.iop0_ack, bus.iop1_ack, bus.err, bus.mem_we, bus.timeout_flag}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.rd_data} !== 81'b0)
            begin fails++; $display("FAIL reset_data got=%h/%h/%h want=0", bus.mem_addr, bus.mem_wdata, bus.rd_data); end
        clear_reqs();
        bus.mem_done = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        obs_t o;
        rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 17'h00100; rwd[0] = 32'h0BAD0BAD;
        access(2, 32'h22100005, 1'b1, o);
        checks++; if (o.none !== 1'b0 || o.hung !== 1'b0) begin fails++; $display("FAIL cpu_rd_started got none=%b hung=%b want 0/0", o.none, o.hung); end
        checks++; if (o.grant !== 2'd0) begin fails++; $display("FAIL cpu_rd_grant got=%0d want=0", o.grant); end
        checks++; if (o.addr !== 17'h00100 || o.we !== 1'b0) begin fails++; $display("FAIL cpu_rd_addr got=%h we=%b want=00100 we=0", o.addr, o.we); end
        checks++; if (o.ack !== 3'b001) begin fails++; $display("FAIL cpu_rd_ack got=%b want=001", o.ack); end
        checks++; if (o.rd !== 32'h22100005 || o.err !== 1'b0) begin fails++; $display("FAIL cpu_rd_data got=%h err=%b want=22100005 err=0", o.rd, o.err); end
        checks++; if (o.req_cycles !== 3) begin fails++; $display("FAIL cpu_rd_reqcyc got=%0d want=3", o.req_cycles); end
        checks++; if (o.busy_after !== 1'b0 || o.grant_after !== 2'd3 || o.ack_after !== 3'b000)
            begin fails++; $display("FAIL cpu_rd_after got busy=%b grant=%0d ack=%b want 0/3/000", o.busy_after, o.grant_after, o.ack_after); end
    endtask

    task automatic test_iop_priority();
        obs_t o;
        rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 17'h00777; rwd[0] = 32'h0;
        rq[1] = 1'b1; rwe[1] = 1'b1; raddr[1] = 17'h01FFF; rwd[1] = 32'hDEADBEEF;
        access(1, 32'h11111111, 1'b1, o);
        checks++; if (o.grant !== 2'd1) begin fails++; $display("FAIL iop_first_grant got=%0d want=1", o.grant); end
        checks++; if (o.we !== 1'b1 || o.wdata !== 32'hDEADBEEF || o.addr !== 17'h01FFF)
            begin fails++; $display("FAIL iop_write_latch got we=%b d=%h a=%h want 1/DEADBEEF/01FFF", o.we, o.wdata, o.addr); end
        checks++; if (o.ack !== 3'b010 || o.err !== 1'b0) begin fails++; $display("FAIL iop_write_ack got=%b err=%b want=010 err=0", o.ack, o.err); end
        checks++; if (o.rd !== 32'h22100005) begin fails++; $display("FAIL iop_write_rd_kept got=%h want=22100005", o.rd); end
        access(0, 32'h5A5A1234, 1'b1, o);
        checks++; if (o.grant !== 2'd0 || o.ack !== 3'b001) begin fails++; $display("FAIL cpu_second_grant got=%0d ack=%b want=0 ack=001", o.grant, o.ack); end
        checks++; if (o.rd !== 32'h5A5A1234) begin fails++; $display("FAIL cpu_second_rd got=%h want=5A5A1234", o.rd); end
    endtask

    task automatic test_starve();
        obs_t o;
        int exp_seq[10];
        exp_seq = '{1, 2, 1, 2, 0, 1, 2, 1, 2, 0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            rq[i] = 1'b1; rwe[i] = 1'($urandom_range(0, 1)); raddr[i] = 17'($urandom); rwd[i] = $urandom;
        end
        for (int k = 0; k < 10; k++) begin
            access($urandom_range(0, 3), $urandom, 1'b0, o);
            checks++; if (o.grant !== 2'(exp_seq[k]) || o.ack !== 3'(1 << exp_seq[k]))
                begin fails++; $display("FAIL starve_seq[%0d] got grant=%0d ack=%b want grant=%0d", k, o.grant, o.ack, exp_seq[k]); end
        end
        clear_reqs();
    endtask

    task automatic test_timeout();
        obs_t o;
        apply_reset();
        rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 17'h00042;
        access(1, 32'h12345678, 1'b0, o);
        checks++; if (o.rd !== 32'h12345678 || o.tflag !== 1'b0) begin fails++; $display("FAIL to_pre_rd got=%h tflag=%b want=12345678 tflag=0", o.rd, o.tflag); end
        access(1000, 32'h0, 1'b1, o);
        checks++; if (o.hung !== 1'b0 || o.ack !== 3'b001) begin fails++; $display("FAIL to_ack got=%b hung=%b want=001 hung=0", o.ack, o.hung); end
        checks++; if (o.req_cycles !== TIMEOUT) begin fails++; $display("FAIL to_reqcyc got=%0d want=%0d", o.req_cycles, TIMEOUT); end
        checks++; if (o.err !== 1'b1 || o.rd !== 32'h0) begin fails++; $display("FAIL to_err got err=%b rd=%h want err=1 rd=0", o.err, o.rd); end
        checks++; if (o.tflag !== 1'b1) begin fails++; $display("FAIL to_flag_set got=%b want=1", o.tflag); end
        rq[2] = 1'b1; rwe[2] = 1'b0; raddr[2] = 17'h10000;
        access(0, 32'hA5A5C3C3, 1'b1, o);
        checks++; if (o.err !== 1'b0 || o.rd !== 32'hA5A5C3C3 || o.ack !== 3'b100)
            begin fails++; $display("FAIL to_next_ok got err=%b rd=%h ack=%b want 0/A5A5C3C3/100", o.err, o.rd, o.ack); end
        checks++; if (o.tflag !== 1'b1) begin fails++; $display("FAIL to_flag_sticky got=%b want=1", o.tflag); end
        apply_reset();
        checks++; if (bus.timeout_flag !== 1'b0) begin fails++; $display("FAIL to_flag_reset got=%b want=0", bus.timeout_flag); end
    endtask

    task automatic test_coincide();
        obs_t o;
        apply_reset();
        rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 17'h0F0F0;
        access(TIMEOUT - 1, 32'hC0FFEE01, 1'b1, o);
        checks++; if (o.err !== 1'b0 || o.rd !== 32'hC0FFEE01) begin fails++; $display("FAIL coin_data got err=%b rd=%h want 0/C0FFEE01", o.err, o.rd); end
        checks++; if (o.req_cycles !== TIMEOUT) begin fails++; $display("FAIL coin_reqcyc got=%0d want=%0d", o.req_cycles, TIMEOUT); end
        checks++; if (o.tflag !== 1'b0) begin fails++; $display("FAIL coin_flag got=%b want=0", o.tflag); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic seen_ack;
        apply_reset();
        rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 17'h00300;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL rmid_started got=%b want=1", bus.mem_req); end
        @(negedge clk);
        rst_n = 1'b0;
        rq[0] = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0 || bus.grant !== 2'd3 || bus.busy !== 1'b0)
            begin fails++; $display("FAIL rmid_abort got req=%b grant=%0d busy=%b want 0/3/0", bus.mem_req, bus.grant, bus.busy); end
        rst_n = 1'b1;
        seen_ack = 1'b0;
        // Stray completions while idle must not produce anything.
        for (int k = 0; k < 4; k++) begin
            bus.mem_done = 1'b1;
            bus.mem_rdata = $urandom;
            @(negedge clk);
            seen_ack = seen_ack | bus.cpu_ack | bus.iop0_ack | bus.iop1_ack | bus.busy | bus.mem_req;
        end
        bus.mem_done = 1'b0;
        checks++; if (seen_ack !== 1'b0) begin fails++; $display("FAIL rmid_silent got activity=%b want=0", seen_ack); end
        rq[0] = 1'b1; raddr[0] = 17'h00301;
        access(3, 32'h600DF00D, 1'b1, o);
        checks++; if (o.ack !== 3'b001 || o.rd !== 32'h600DF00D || o.err !== 1'b0 || o.addr !== 17'h00301)
            begin fails++; $display("FAIL rmid_fresh got ack=%b rd=%h err=%b a=%h want 001/600DF00D/0/00301", o.ack, o.rd, o.err, o.addr); end
    endtask

    task automatic test_random();
        obs_t o;
        int starve, win, dly, sel, exp_cyc;
        logic rr_iop1, exp_tflag, timed;
        logic [31:0] exp_rd, rdat;
        int order[2];
        apply_reset();
        starve = 0; rr_iop1 = 1'b0; exp_tflag = 1'b0; exp_rd = 32'h0;
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < 3; i++)
                if (!rq[i] && $urandom_range(0, 2) != 0) begin
                    rq[i] = 1'b1; rwe[i] = 1'($urandom_range(0, 1));
                    raddr[i] = 17'($urandom); rwd[i] = $urandom;
                end
            // Reference: starved CPU first, then IOPs in pointer order, then CPU.
            order[0] = rr_iop1 ? 2 : 1;
            order[1] = rr_iop1 ? 1 : 2;
            win = 3;
            if (rq[0] && starve == SLIM) win = 0;
            else begin
                for (int k = 1; k >= 0; k--) if (rq[order[k]]) win = order[k];
                if (win == 3 && rq[0]) win = 0;
            end
            if (win == 0 || !rq[0]) starve = 0;
            else if (win != 3) starve = (starve + 1 > SLIM) ? SLIM : starve + 1;
            if (win == 1) rr_iop1 = 1'b1;
            if (win == 2) rr_iop1 = 1'b0;
            sel = $urandom_range(0, 9);
            dly = (sel < 7) ? $urandom_range(0, 4) : (sel == 7) ? TIMEOUT - 1 : (sel == 8) ? TIMEOUT - 2 : 500;
            rdat = $urandom;
            access(dly, rdat, ($urandom_range(0, 3) != 0), o);
            if (win == 3) begin
                checks++; if (o.none !== 1'b1 || o.grant !== 2'd3) begin fails++; $display("FAIL rnd[%0d]_idle got none=%b grant=%0d want 1/3", t, o.none, o.grant); end
                continue;
            end
            timed = (dly > TIMEOUT - 1);
            exp_cyc = timed ? TIMEOUT : dly + 1;
            if (timed) exp_rd = 32'h0;
            else if (!rwe[win]) exp_rd = rdat;
            exp_tflag = exp_tflag | timed;
            checks++; if (o.grant !== 2'(win) || o.ack !== 3'(1 << win))
                begin fails++; $display("FAIL rnd[%0d]_grant got=%0d ack=%b want=%0d", t, o.grant, o.ack, win); end
            checks++; if (o.addr !== raddr[win] || o.we !== rwe[win] || o.wdata !== rwd[win])
                begin fails++; $display("FAIL rnd[%0d]_latch got a=%h we=%b d=%h want a=%h we=%b d=%h", t, o.addr, o.we, o.wdata, raddr[win], rwe[win], rwd[win]); end
            checks++; if (o.rd !== exp_rd || o.err !== timed || o.tflag !== exp_tflag)
                begin fails++; $display("FAIL rnd[%0d]_result got rd=%h err=%b tf=%b want rd=%h err=%b tf=%b", t, o.rd, o.err, o.tflag, exp_rd, timed, exp_tflag); end
            checks++; if (o.req_cycles !== exp_cyc || o.busy_after !== 1'b0 || o.grant_after !== 2'd3 || o.ack_after !== 3'b000)
                begin fails++; $display("FAIL rnd[%0d]_timing got cyc=%0d busy=%b g=%0d ack=%b want cyc=%0d 0/3/000", t, o.req_cycles, o.busy_after, o.grant_after, o.ack_after, exp_cyc); end
        end
        clear_reqs();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rq[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rwd[i] = '0;
        end
        bus.mem_done  = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_cpu_read();
        test_iop_priority();
        test_starve();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish (checks=%0d)", checks);
        $fatal(1);
    end
endmodule
